// File: rtl/marquee_scroller.sv
// Scrolling 7-segment marquee: prescaled scroll steps over a small writable
// symbol buffer, with wrap and bounce modes and registered segment outputs.
module marquee_scroller #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned MSG_LEN  = 8,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                       clk,
    input  logic                       aclr,
    input  logic                       run,
    input  logic                       dir,
    input  logic                       mode,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [2:0]                 wr_data,
    output logic [7*DIGITS-1:0]        hex,
    output logic [$clog2(MSG_LEN)-1:0] pos,
    output logic                       tick
);

    localparam int unsigned AW = $clog2(MSG_LEN);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
    localparam logic [AW-1:0] POS_MAX  = AW'(MSG_LEN - DIGITS);
    localparam logic [AW-1:0] POS_LAST = AW'(MSG_LEN - 1);

    typedef enum logic {
        ST_FWD = 1'b0,
        ST_REV = 1'b1
    } state_t;

    logic [CW-1:0]       r_cnt;
    logic [AW-1:0]       r_pos;
    logic [AW-1:0]       w_pos_nxt;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_msg [MSG_LEN];
    logic [7*DIGITS-1:0] r_hex;
    logic [7*DIGITS-1:0] w_hex_nxt;
    logic                w_tick;

    // Active-low segments a..g, a in the MSB.
    function automatic logic [6:0] seg_of(input logic [2:0] s);
        case (s)
            3'd0:    seg_of = 7'b1001000;
            3'd1:    seg_of = 7'b0110000;
            3'd2:    seg_of = 7'b1110001;
            3'd3:    seg_of = 7'b0000001;
            3'd4:    seg_of = 7'b0011000;
            3'd5:    seg_of = 7'b0001000;
            3'd6:    seg_of = 7'b1111110;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    assign w_tick = aclr & run & (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!aclr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!aclr) begin
            r_state <= ST_FWD;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    // Bounce state is only advanced in bounce mode, so wrap mode preserves it.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        if (w_tick) begin
            if (!mode) begin
                if (dir) begin
                    w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + AW'(1);
                end else begin
                    w_pos_nxt = (r_pos == '0) ? POS_LAST : r_pos - AW'(1);
                end
            end else if (POS_MAX == '0) begin
                w_pos_nxt = '0;
            end else if (r_pos > POS_MAX) begin
                w_pos_nxt   = POS_MAX;
                w_state_nxt = ST_REV;
            end else begin
                case (r_state)
                    ST_FWD: begin
                        if (r_pos < POS_MAX) begin
                            w_pos_nxt = r_pos + AW'(1);
                        end else begin
                            w_pos_nxt   = r_pos - AW'(1);
                            w_state_nxt = ST_REV;
                        end
                    end
                    default: begin
                        if (r_pos != '0) begin
                            w_pos_nxt = r_pos - AW'(1);
                        end else begin
                            w_pos_nxt   = r_pos + AW'(1);
                            w_state_nxt = ST_FWD;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aclr) begin
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                r_msg[i] <= (i < 4) ? 3'(i) : 3'd7;
            end
        end else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_LEN))) begin
            r_msg[wr_addr] <= wr_data;
        end
    end

    // pos+k never exceeds 2*MSG_LEN-2, so one conditional subtract is a full modulo.
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        logic [AW:0]   w_sum;
        logic [AW-1:0] w_idx;
        assign w_sum = {1'b0, r_pos} + (AW+1)'(k);
        assign w_idx = (w_sum >= (AW+1)'(MSG_LEN)) ? AW'(w_sum - (AW+1)'(MSG_LEN))
                                                   : AW'(w_sum);
        assign w_hex_nxt[7*k +: 7] = seg_of(r_msg[w_idx]);
    end

    always_ff @(posedge clk) begin
        if (!aclr) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_hex_nxt;
        end
    end

    assign hex  = r_hex;
    assign pos  = r_pos;
    assign tick = w_tick;

endmodule

// File: tb/tb_marquee_scroller.sv
// Directed bench for marquee_scroller (DIGITS=4, MSG_LEN=8, TICK_DIV=4).
module tb_marquee_scroller;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned MSG_LEN  = 8;
    localparam int unsigned TICK_DIV = 4;

    localparam int S_H = 0, S_E = 1, S_L = 2, S_O = 3, S_A = 5, S_BL = 7;

    logic        clk = 1'b0;
    logic        aclr = 1'b0;
    logic        run = 1'b0;
    logic        dir = 1'b1;
    logic        mode = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [2:0]  wr_data = '0;
    logic [27:0] hex;
    logic [2:0]  pos;
    logic        tick;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    marquee_scroller #(
        .DIGITS  (DIGITS),
        .MSG_LEN (MSG_LEN),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk    (clk),
        .aclr   (aclr),
        .run    (run),
        .dir    (dir),
        .mode   (mode),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .hex    (hex),
        .pos    (pos),
        .tick   (tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int s);
        case (s)
            0:       return 7'b1001000;
            1:       return 7'b0110000;
            2:       return 7'b1110001;
            3:       return 7'b0000001;
            4:       return 7'b0011000;
            5:       return 7'b0001000;
            6:       return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    // Leftmost digit sits in the low bits.
    function automatic logic [27:0] disp(input int d0, input int d1, input int d2, input int d3);
        return {seg(d3), seg(d2), seg(d1), seg(d0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int waited);
        waited = 0;
        while (!tick && waited < 32) begin
            step();
            waited++;
        end
        if (!tick) chk("tick_seen", 32'(tick), 32'd1);
    endtask

    task automatic do_tick(output int waited);
        wait_tick(waited);
        step();
    endtask

    task automatic do_reset();
        aclr = 1'b0;
        run  = 1'b0;
        step();
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_hex", 32'(hex), 32'h0FFFFFFF);
        chk("rst_tick", 32'(tick), 32'd0);
        aclr = 1'b1;
        step();
        chk("helo_hex", 32'(hex), 32'(disp(S_H, S_E, S_L, S_O)));
    endtask

    initial begin
        int w;
        int exp_w;
        int exp_b[9];
        exp_b = '{1, 2, 3, 4, 3, 2, 1, 0, 1};

        do_reset();

        // Wrap forward through a full lap.
        mode = 1'b0; dir = 1'b1; run = 1'b1;
        exp_w = 3;
        for (int i = 0; i < 8; i++) begin
            do_tick(w);
            chk("wrap_period", 32'(w), 32'(exp_w));
            exp_w = 3;
            chk("wrap_pos", 32'(pos), 32'((i + 1) % 8));
            if (i == 5) begin
                step();
                chk("hex_pos6", 32'(hex), 32'(disp(S_BL, S_BL, S_H, S_E)));
                exp_w = 2;
            end
        end

        // Wrap backward from 0.
        dir = 1'b0;
        do_tick(w);
        chk("wrap_dec_pos", 32'(pos), 32'd7);
        step();
        chk("hex_pos7", 32'(hex), 32'(disp(S_BL, S_H, S_E, S_L)));

        // Bounce from reset.
        do_reset();
        mode = 1'b1; dir = 1'b1; run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            do_tick(w);
            chk("bounce_pos", 32'(pos), 32'(exp_b[i]));
        end

        // Switch to bounce beyond MAX, then check state survives wrap mode.
        do_reset();
        mode = 1'b0; dir = 1'b1; run = 1'b1;
        repeat (6) do_tick(w);
        chk("pre_sw_pos", 32'(pos), 32'd6);
        mode = 1'b1;
        do_tick(w); chk("clamp_pos", 32'(pos), 32'd4);
        do_tick(w); chk("rev_pos1", 32'(pos), 32'd3);
        do_tick(w); chk("rev_pos2", 32'(pos), 32'd2);
        mode = 1'b0;
        do_tick(w); chk("wrap_mid", 32'(pos), 32'd3);
        mode = 1'b1;
        do_tick(w); chk("resume_rev", 32'(pos), 32'd2);

        // Freeze mid-count.
        do_reset();
        mode = 1'b0; dir = 1'b1; run = 1'b1;
        step();
        step();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("frz_tick", 32'(tick), 32'd0);
            step();
            chk("frz_pos", 32'(pos), 32'd0);
        end
        run = 1'b1;
        do_tick(w);
        chk("resume_wait", 32'(w), 32'd1);
        chk("resume_pos", 32'(pos), 32'd1);

        // Write coincident with tick, then reset mid-scroll.
        do_reset();
        mode = 1'b0; dir = 1'b1; run = 1'b1;
        wait_tick(w);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 3'd5;
        step();
        wr_en = 1'b0;
        chk("wt_pos", 32'(pos), 32'd1);
        chk("wt_hex_lag", 32'(hex), 32'(disp(S_H, S_E, S_L, S_O)));
        step();
        chk("wt_hex", 32'(hex), 32'(disp(S_E, S_L, S_O, S_A)));
        step();
        aclr = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 3'd6;
        step();
        chk("mid_rst_pos", 32'(pos), 32'd0);
        chk("mid_rst_hex", 32'(hex), 32'h0FFFFFFF);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        wr_en = 1'b0;
        aclr = 1'b1;
        step();
        chk("post_rst_helo", 32'(hex), 32'(disp(S_H, S_E, S_L, S_O)));
        do_tick(w);
        chk("post_rst_pos", 32'(pos), 32'd1);
        step();
        chk("post_rst_msg", 32'(hex), 32'(disp(S_E, S_L, S_O, S_BL)));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
